// File: rtl/jam_cost_responder.sv
// -----------------------------------------------------------------------------
// jam_cost_responder
//   Cost-matrix responder and result checker for the JAM job-assignment engine.
//   An 8x8 worker/job cost matrix is loaded through a valid/ready port while
//   JAM is held in reset. Once all 64 words are in, JAM is released and its
//   W/J index requests are answered on Cost with one cycle of latency. The
//   first Valid result is captured and compared against the expected values.
//   If no result arrives within TIMEOUT_CYCLES, the check ends as a timeout.
//
// Ports
//   CLK, RST_N           clock (rising edge), asynchronous active-low reset
//   ld_valid/ld_ready    load handshake; ld_data is the cost word (row-major, W*8+J)
//   exp_min_cost         expected minimum cost
//   exp_match_count      expected match count
//   jam_rst              active-high reset to JAM, released after the load
//   W, J, Cost           index request from JAM; Cost = mem[{W,J}] one cycle later
//   Valid, MinCost,
//   MatchCount           JAM result
//   done, pass, timeout  check status (sticky until reset)
//   got_min_cost,
//   got_match_count      captured JAM result
// -----------------------------------------------------------------------------
module jam_cost_responder #(
    parameter int COST_W         = 7,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [COST_W-1:0] ld_data,
    input  logic [9:0]        exp_min_cost,
    input  logic [3:0]        exp_match_count,
    output logic              jam_rst,
    input  logic [2:0]        W,
    input  logic [2:0]        J,
    output logic [COST_W-1:0] Cost,
    input  logic              Valid,
    input  logic [9:0]        MinCost,
    input  logic [3:0]        MatchCount,
    output logic              done,
    output logic              pass,
    output logic              timeout,
    output logic [9:0]        got_min_cost,
    output logic [3:0]        got_match_count
);

    // One spare bit so TIMEOUT_CYCLES-1 always fits, even for powers of two.
    localparam int            TW         = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_SERVE = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [5:0]        ptr_q, ptr_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic              ld_ready_q, ld_ready_d;
    logic              jam_rst_q, jam_rst_d;
    logic              done_q, done_d;
    logic              pass_q, pass_d;
    logic              timeout_q, timeout_d;
    logic [9:0]        got_min_cost_q, got_min_cost_d;
    logic [3:0]        got_match_count_q, got_match_count_d;
    logic [COST_W-1:0] cost_q;
    logic [COST_W-1:0] mem_q [64];
    logic              accept_s;
    logic              timer_last_s;
    logic [5:0]        rd_idx_s;

    assign accept_s     = (state_q == ST_LOAD) && ld_valid;
    assign timer_last_s = (timer_q == TIMER_LAST);
    assign rd_idx_s     = {W, J};

    // Next-state logic: the 64th accepted word starts SERVE, the first result or expiry ends it.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_LOAD: begin
                if (accept_s && (ptr_q == 6'd63)) begin
                    state_d = ST_SERVE;
                end else begin
                    state_d = ST_LOAD;
                end
            end
            ST_SERVE: begin
                if (Valid || timer_last_s) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_SERVE;
                end
            end
            ST_DONE: state_d = ST_DONE;
            default: state_d = ST_LOAD;
        endcase
    end

    // Load pointer and SERVE timer; the timer sits at zero throughout LOAD.
    always_comb begin
        ptr_d   = ptr_q;
        timer_d = timer_q;
        if (accept_s) begin
            ptr_d = ptr_q + 6'd1;
        end else begin
            ptr_d = ptr_q;
        end
        case (state_q)
            ST_LOAD:  timer_d = '0;
            ST_SERVE: timer_d = timer_q + TW'(1);
            ST_DONE:  timer_d = timer_q;
            default:  timer_d = '0;
        endcase
    end

    // Output logic: handshake/reset follow the next state; Valid takes priority over expiry.
    always_comb begin
        ld_ready_d        = (state_d == ST_LOAD);
        jam_rst_d         = (state_d == ST_LOAD);
        done_d            = done_q;
        pass_d            = pass_q;
        timeout_d         = timeout_q;
        got_min_cost_d    = got_min_cost_q;
        got_match_count_d = got_match_count_q;
        if (state_q == ST_SERVE) begin
            if (Valid) begin
                got_min_cost_d    = MinCost;
                got_match_count_d = MatchCount;
                pass_d            = (MinCost == exp_min_cost) &&
                                    (MatchCount == exp_match_count);
                done_d            = 1'b1;
            end else if (timer_last_s) begin
                timeout_d = 1'b1;
                done_d    = 1'b1;
                pass_d    = 1'b0;
            end else begin
                done_d = done_q;
            end
        end else begin
            done_d = done_q;
        end
    end

    // Control and status state register.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q           <= ST_LOAD;
            ptr_q             <= 6'd0;
            timer_q           <= '0;
            ld_ready_q        <= 1'b1;
            jam_rst_q         <= 1'b1;
            done_q            <= 1'b0;
            pass_q            <= 1'b0;
            timeout_q         <= 1'b0;
            got_min_cost_q    <= 10'd0;
            got_match_count_q <= 4'd0;
        end else begin
            state_q           <= state_d;
            ptr_q             <= ptr_d;
            timer_q           <= timer_d;
            ld_ready_q        <= ld_ready_d;
            jam_rst_q         <= jam_rst_d;
            done_q            <= done_d;
            pass_q            <= pass_d;
            timeout_q         <= timeout_d;
            got_min_cost_q    <= got_min_cost_d;
            got_match_count_q <= got_match_count_d;
        end
    end

    // Cost matrix storage, cleared by reset so every reload starts from zeros.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < 64; i++) begin
                mem_q[i] <= '0;
            end
        end else if (accept_s) begin
            mem_q[ptr_q] <= ld_data;
        end
    end

    // Lookup register: reads the pre-write contents, so a same-index write returns old data.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cost_q <= '0;
        end else begin
            cost_q <= mem_q[rd_idx_s];
        end
    end

    assign ld_ready        = ld_ready_q;
    assign jam_rst         = jam_rst_q;
    assign Cost            = cost_q;
    assign done            = done_q;
    assign pass            = pass_q;
    assign timeout         = timeout_q;
    assign got_min_cost    = got_min_cost_q;
    assign got_match_count = got_match_count_q;

endmodule

// File: tb/tb_jam_cost_responder.sv
// -----------------------------------------------------------------------------
// tb_jam_cost_responder
//   Self-checking bench for jam_cost_responder (TIMEOUT_CYCLES=16). A behavioural
//   copy of the cost matrix is built from the words the bench sees accepted;
//   Cost is checked against it. The JAM engine is modelled by driving Valid,
//   MinCost and MatchCount directly.
// -----------------------------------------------------------------------------
module tb_jam_cost_responder;

    localparam int COST_W = 7;
    localparam int TO     = 16;

    logic              CLK = 1'b0;
    logic              RST_N;
    logic              ld_valid;
    logic              ld_ready;
    logic [COST_W-1:0] ld_data;
    logic [9:0]        exp_min_cost;
    logic [3:0]        exp_match_count;
    logic              jam_rst;
    logic [2:0]        W, J;
    logic [COST_W-1:0] Cost;
    logic              Valid;
    logic [9:0]        MinCost;
    logic [3:0]        MatchCount;
    logic              done, pass, timeout;
    logic [9:0]        got_min_cost;
    logic [3:0]        got_match_count;

    jam_cost_responder #(.COST_W(COST_W), .TIMEOUT_CYCLES(TO)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data),
        .exp_min_cost(exp_min_cost), .exp_match_count(exp_match_count),
        .jam_rst(jam_rst), .W(W), .J(J), .Cost(Cost),
        .Valid(Valid), .MinCost(MinCost), .MatchCount(MatchCount),
        .done(done), .pass(pass), .timeout(timeout),
        .got_min_cost(got_min_cost), .got_match_count(got_match_count)
    );

    always #5 CLK = ~CLK;

    int errors = 0;
    int checks = 0;
    logic [COST_W-1:0] load_buf  [64];
    logic [COST_W-1:0] model_mem [64];

    typedef struct {
        logic [2:0]        w;
        logic [2:0]        j;
        logic [COST_W-1:0] exp_cost;
    } lk_vec_t;
    lk_vec_t tbl [6];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RST_N = 1'b0; ld_valid = 1'b0; ld_data = '0; W = 3'd0; J = 3'd0;
        Valid = 1'b0; MinCost = 10'd0; MatchCount = 4'd0;
        exp_min_cost = 10'd8; exp_match_count = 4'd1;
        for (int i = 0; i < 64; i++) model_mem[i] = '0;
        tick(); tick();
        RST_N = 1'b1;
    endtask

    // mode 0: back-to-back, 1: every other cycle, 2: random gaps + same-index read.
    task automatic load(input int mode, input int nwords);
        int k = 0;
        int cyc = 0;
        int pre_bad = 0;
        logic acc;
        while (k < nwords && cyc < 1000) begin
            case (mode)
                0:       ld_valid = 1'b1;
                1:       ld_valid = (cyc % 2 == 0);
                default: ld_valid = 1'($urandom_range(0, 1));
            endcase
            ld_data = load_buf[k];
            if (mode == 2) {W, J} = 6'(k);
            if (jam_rst !== 1'b1) pre_bad++;
            acc = ld_valid && ld_ready;
            tick();
            if (mode == 2) check("same_index_old_value", Cost, 0);
            if (acc) begin
                model_mem[k] = load_buf[k];
                k++;
            end
            cyc++;
        end
        ld_valid = 1'b0;
        check("load_words_accepted", k, nwords);
        check("jam_rst_high_during_load", pre_bad, 0);
    endtask

    task automatic lookup(input string nm, input logic [2:0] w, input logic [2:0] j);
        W = w; J = j;
        tick();
        check(nm, Cost, model_mem[{w, j}]);
    endtask

    task automatic fill_diag();
        for (int i = 0; i < 64; i++) load_buf[i] = (i / 8 == i % 8) ? 7'd1 : 7'd50;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // ---------------- reset state ----------------
        do_reset();
        check("rst_ld_ready", ld_ready, 1);
        check("rst_jam_rst", jam_rst, 1);
        check("rst_cost", Cost, 0);
        check("rst_done", done, 0);
        check("rst_pass", pass, 0);
        check("rst_timeout", timeout, 0);
        check("rst_got_min", got_min_cost, 0);
        check("rst_got_cnt", got_match_count, 0);

        // ---------------- test 1 + 3: gapped load, passing result ----------------
        fill_diag();
        Valid = 1'b1; MinCost = 10'd5; MatchCount = 4'd2;    // ignored in LOAD
        tick(); tick();
        Valid = 1'b0;
        load(1, 64);
        check("t3_jam_rst_released", jam_rst, 0);
        check("t3_ld_ready_low", ld_ready, 0);
        check("t1_no_done_from_load_valid", done, 0);
        lookup("t1_cost_diag", 3'd2, 3'd2);
        lookup("t1_cost_off", 3'd2, 3'd3);
        Valid = 1'b1; MinCost = 10'd8; MatchCount = 4'd1;
        tick();
        check("t1_done", done, 1);
        check("t1_pass", pass, 1);
        check("t1_got_min", got_min_cost, 8);
        check("t1_got_cnt", got_match_count, 1);
        MinCost = 10'd3;
        tick();
        check("t1_first_valid_only", got_min_cost, 8);
        check("t1_done_sticky", done, 1);
        Valid = 1'b0;

        // ---------------- test 2 + 4: table lookups, failing result ----------------
        do_reset();
        for (int i = 0; i < 64; i++) load_buf[i] = (i == 29) ? 7'd17 : 7'(i + 40);
        tbl[0] = '{3'd3, 3'd5, 7'd17};
        tbl[1] = '{3'd0, 3'd0, 7'd40};
        tbl[2] = '{3'd7, 3'd7, 7'd103};
        tbl[3] = '{3'd1, 3'd2, 7'd50};
        tbl[4] = '{3'd6, 3'd3, 7'd91};
        tbl[5] = '{3'd3, 3'd5, 7'd17};
        load(0, 64);
        ld_valid = 1'b1; ld_data = 7'd127;                   // ignored outside LOAD
        W = 3'd3; J = 3'd5;
        tick();
        check("t2_cost_latency_1", Cost, 17);
        tick(); tick();
        ld_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            W = tbl[i].w; J = tbl[i].j;
            tick();
            check($sformatf("t2_table_%0d", i), Cost, tbl[i].exp_cost);
        end
        Valid = 1'b1; MinCost = 10'd9; MatchCount = 4'd1;
        tick();
        Valid = 1'b0;
        check("t4_done", done, 1);
        check("t4_pass", pass, 0);
        check("t4_got_min", got_min_cost, 9);
        check("t4_timeout", timeout, 0);

        // ---------------- random load and lookups ----------------
        do_reset();
        for (int i = 0; i < 64; i++) load_buf[i] = 7'($urandom_range(0, 127));
        load(2, 64);
        for (int i = 0; i < 60; i++) begin
            ld_valid = 1'($urandom_range(0, 1));
            ld_data  = 7'($urandom_range(0, 127));
            lookup("rand_lookup", 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
        end
        ld_valid = 1'b0;

        // ---------------- test 5: timeout ----------------
        do_reset();
        fill_diag();
        load(0, 64);
        begin
            int n = 0;
            while (!done && n < 40) begin
                tick();
                n++;
            end
            check("t5_timeout_cycle", n, TO);
        end
        check("t5_timeout", timeout, 1);
        check("t5_pass", pass, 0);
        lookup("t5_cost_in_done", 3'd4, 3'd4);

        do_reset();
        load(0, 64);
        for (int i = 0; i < TO - 1; i++) tick();
        check("t5b_not_done_yet", done, 0);
        Valid = 1'b1; MinCost = 10'd8; MatchCount = 4'd1;
        tick();
        Valid = 1'b0;
        check("t5b_done", done, 1);
        check("t5b_timeout_lost", timeout, 0);
        check("t5b_pass", pass, 1);

        // ---------------- test 6: reset mid-load ----------------
        do_reset();
        for (int i = 0; i < 64; i++) load_buf[i] = 7'(i + 60);
        load(0, 30);
        check("t6_still_loading", jam_rst, 1);
        RST_N = 1'b0;
        #1;
        for (int i = 0; i < 64; i++) model_mem[i] = '0;
        check("t6_async_jam_rst", jam_rst, 1);
        check("t6_async_ld_ready", ld_ready, 1);
        check("t6_async_cost", Cost, 0);
        tick();
        RST_N = 1'b1;
        lookup("t6_mem_cleared", 3'd0, 3'd5);
        fill_diag();
        load(0, 64);
        lookup("t6_reload_idx0", 3'd0, 3'd0);
        lookup("t6_reload_idx40", 3'd5, 3'd0);
        Valid = 1'b1; MinCost = 10'd8; MatchCount = 4'd1;
        tick();
        Valid = 1'b0;
        check("t6_done", done, 1);
        check("t6_pass", pass, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
